// File: rtl/sec_xfer_ctrl_if.sv
// Command and response handshake between a requester and the transfer sequencer.
interface sec_xfer_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [7:0]  cmd_mem_addr;
    logic [7:0]  cmd_reg_addr;
    logic [3:0]  cmd_len;
    logic [15:0] cmd_key;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_status;
    logic [4:0]  resp_words;

    modport master (
        output cmd_valid, cmd_op, cmd_mem_addr, cmd_reg_addr, cmd_len, cmd_key, resp_ready,
        input  cmd_ready, resp_valid, resp_status, resp_words
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_mem_addr, cmd_reg_addr, cmd_len, cmd_key, resp_ready,
        output cmd_ready, resp_valid, resp_status, resp_words
    );
endinterface

// File: rtl/sec_xfer_ctrl.sv
// Command/response sequencer that checks access keys and issues per-word read-then-write
// enable pulses across the memory <-> security <-> register path. Moves no data itself.
module sec_xfer_ctrl #(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    sec_xfer_ctrl_if.slave   bus,
    input  logic [15:0]      key_access_mem,
    input  logic [15:0]      key_access_reg,
    input  logic             abort,
    output logic [7:0]       mem_read_address_reg,
    output logic             mem_renable_reg,
    output logic [7:0]       mem_write_address_reg,
    output logic             mem_wenable_reg,
    output logic [7:0]       reg_address_to_mem,
    output logic             reg_renable_mem,
    output logic [7:0]       reg_address_mem,
    output logic             reg_wenable_mem,
    output logic             busy,
    output logic [CNT_W-1:0] xfer_count,
    output logic [7:0]       deny_count
);

    localparam int unsigned WAIT_W = 2;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(RD_LAT - 1);

    localparam logic       OP_LOAD     = 1'b0;
    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_DENIED   = 2'd1;
    localparam logic [1:0] ST_RANGE    = 2'd2;
    localparam logic [1:0] ST_ABORTED  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t             r_state;
    logic               r_op;
    logic [7:0]         r_mem_addr;
    logic [7:0]         r_reg_addr;
    logic [3:0]         r_len;
    logic [15:0]        r_key;
    logic [4:0]         r_words;
    logic [WAIT_W-1:0]  r_wait;
    logic [1:0]         r_status;
    logic               r_resp_valid;
    logic               r_cmd_ready;
    logic               r_busy;
    logic [CNT_W-1:0]   r_xfer_count;
    logic [7:0]         r_deny_count;
    logic               r_mem_ren;
    logic               r_mem_wen;
    logic               r_reg_ren;
    logic               r_reg_wen;
    logic [7:0]         r_mem_raddr;
    logic [7:0]         r_mem_waddr;
    logic [7:0]         r_reg_raddr;
    logic [7:0]         r_reg_waddr;

    logic               w_key_ok;
    logic [8:0]         w_mem_end;
    logic [8:0]         w_reg_end;
    logic               w_range_err;
    logic               w_last;
    logic [7:0]         w_mem_addr_nxt;
    logic [7:0]         w_reg_addr_nxt;

    // The key that must match depends on which side is being read.
    assign w_key_ok       = (r_op == OP_LOAD) ? (r_key == key_access_mem) : (r_key == key_access_reg);
    assign w_mem_end      = {1'b0, r_mem_addr} + {5'd0, r_len};
    assign w_reg_end      = {1'b0, r_reg_addr} + {5'd0, r_len};
    assign w_range_err    = (w_mem_end > 9'd255) || (w_reg_end > 9'd255);
    assign w_last         = (r_words == 5'(r_len));
    assign w_mem_addr_nxt = r_mem_addr + 8'd1;
    assign w_reg_addr_nxt = r_reg_addr + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_op         <= 1'b0;
            r_mem_addr   <= 8'd0;
            r_reg_addr   <= 8'd0;
            r_len        <= 4'd0;
            r_key        <= 16'd0;
            r_words      <= 5'd0;
            r_wait       <= '0;
            r_status     <= ST_OK;
            r_resp_valid <= 1'b0;
            r_cmd_ready  <= 1'b0;
            r_busy       <= 1'b0;
            r_xfer_count <= '0;
            r_deny_count <= 8'd0;
            r_mem_ren    <= 1'b0;
            r_mem_wen    <= 1'b0;
            r_reg_ren    <= 1'b0;
            r_reg_wen    <= 1'b0;
            r_mem_raddr  <= 8'd0;
            r_mem_waddr  <= 8'd0;
            r_reg_raddr  <= 8'd0;
            r_reg_waddr  <= 8'd0;
        end else begin
            // Strobes are single-cycle pulses unless a state entry below raises one.
            r_mem_ren <= 1'b0;
            r_mem_wen <= 1'b0;
            r_reg_ren <= 1'b0;
            r_reg_wen <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid && r_cmd_ready) begin
                        r_op        <= bus.cmd_op;
                        r_mem_addr  <= bus.cmd_mem_addr;
                        r_reg_addr  <= bus.cmd_reg_addr;
                        r_len       <= bus.cmd_len;
                        r_key       <= bus.cmd_key;
                        r_words     <= 5'd0;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_CHECK;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end

                S_CHECK: begin
                    if (!w_key_ok) begin
                        r_status     <= ST_DENIED;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_DONE;
                        if (r_deny_count != 8'hFF) begin
                            r_deny_count <= r_deny_count + 8'd1;
                        end
                    end else if (w_range_err) begin
                        r_status     <= ST_RANGE;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        r_state <= S_READ;
                        if (r_op == OP_LOAD) begin
                            r_mem_ren   <= 1'b1;
                            r_mem_raddr <= r_mem_addr;
                        end else begin
                            r_reg_ren   <= 1'b1;
                            r_reg_raddr <= r_reg_addr;
                        end
                    end
                end

                S_READ: begin
                    if (abort) begin
                        r_status     <= ST_ABORTED;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        r_wait  <= WAIT_INIT;
                        r_state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (abort) begin
                        r_status     <= ST_ABORTED;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_DONE;
                    end else if (r_wait == '0) begin
                        r_state <= S_WRITE;
                        if (r_op == OP_LOAD) begin
                            r_reg_wen   <= 1'b1;
                            r_reg_waddr <= r_reg_addr;
                        end else begin
                            r_mem_wen   <= 1'b1;
                            r_mem_waddr <= r_mem_addr;
                        end
                    end else begin
                        r_wait <= r_wait - WAIT_W'(1);
                    end
                end

                // The write strobe is already out this cycle, so an abort here lets it land.
                S_WRITE: begin
                    r_words      <= r_words + 5'd1;
                    r_xfer_count <= r_xfer_count + CNT_W'(1);
                    if (w_last) begin
                        r_status     <= ST_OK;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_DONE;
                    end else if (abort) begin
                        r_status     <= ST_ABORTED;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        r_mem_addr <= w_mem_addr_nxt;
                        r_reg_addr <= w_reg_addr_nxt;
                        r_state    <= S_READ;
                        if (r_op == OP_LOAD) begin
                            r_mem_ren   <= 1'b1;
                            r_mem_raddr <= w_mem_addr_nxt;
                        end else begin
                            r_reg_ren   <= 1'b1;
                            r_reg_raddr <= w_reg_addr_nxt;
                        end
                    end
                end

                S_DONE: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_cmd_ready  <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready         = r_cmd_ready;
    assign bus.resp_valid        = r_resp_valid;
    assign bus.resp_status       = r_status;
    assign bus.resp_words        = r_words;
    assign mem_read_address_reg  = r_mem_raddr;
    assign mem_renable_reg       = r_mem_ren;
    assign mem_write_address_reg = r_mem_waddr;
    assign mem_wenable_reg       = r_mem_wen;
    assign reg_address_to_mem    = r_reg_raddr;
    assign reg_renable_mem       = r_reg_ren;
    assign reg_address_mem       = r_reg_waddr;
    assign reg_wenable_mem       = r_reg_wen;
    assign busy                  = r_busy;
    assign xfer_count            = r_xfer_count;
    assign deny_count            = r_deny_count;

endmodule

// File: tb/tb_sec_xfer_ctrl.sv
// Bench for sec_xfer_ctrl: directed and random commands checked against a timeline model.
module tb_sec_xfer_ctrl;

    localparam int unsigned RD_LAT = 1;
    localparam int unsigned CNT_W  = 16;
    localparam int          P      = 2 + RD_LAT;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [15:0]       key_access_mem;
    logic [15:0]       key_access_reg;
    logic              abort;
    logic [7:0]        mem_read_address_reg;
    logic              mem_renable_reg;
    logic [7:0]        mem_write_address_reg;
    logic              mem_wenable_reg;
    logic [7:0]        reg_address_to_mem;
    logic              reg_renable_mem;
    logic [7:0]        reg_address_mem;
    logic              reg_wenable_mem;
    logic              busy;
    logic [CNT_W-1:0]  xfer_count;
    logic [7:0]        deny_count;

    sec_xfer_ctrl_if bus ();

    sec_xfer_ctrl #(.RD_LAT(RD_LAT), .CNT_W(CNT_W)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .bus                   (bus),
        .key_access_mem        (key_access_mem),
        .key_access_reg        (key_access_reg),
        .abort                 (abort),
        .mem_read_address_reg  (mem_read_address_reg),
        .mem_renable_reg       (mem_renable_reg),
        .mem_write_address_reg (mem_write_address_reg),
        .mem_wenable_reg       (mem_wenable_reg),
        .reg_address_to_mem    (reg_address_to_mem),
        .reg_renable_mem       (reg_renable_mem),
        .reg_address_mem       (reg_address_mem),
        .reg_wenable_mem       (reg_wenable_mem),
        .busy                  (busy),
        .xfer_count            (xfer_count),
        .deny_count            (deny_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int exp_xfer = 0;
    int exp_deny = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] strobes();
        return {mem_renable_reg, mem_wenable_reg, reg_renable_mem, reg_wenable_mem};
    endfunction

    // Outcome from the rules: cycle 1 is CHECK, word k reads at 2+k*P and writes at 2+k*P+1+RD_LAT.
    function automatic void model(input bit op, input int ma, input int ra, input int len,
                                  input logic [15:0] key, input int abort_cyc,
                                  output int st, output int words, output int done_cyc);
        int k;
        int ph;
        if (key != (op ? key_access_reg : key_access_mem)) begin
            st = 1; words = 0; done_cyc = 2;
        end else if (ma + len > 255 || ra + len > 255) begin
            st = 2; words = 0; done_cyc = 2;
        end else begin
            st = 0; words = len + 1; done_cyc = 2 + (len + 1) * P;
            if (abort_cyc >= 2 && abort_cyc < done_cyc) begin
                k  = (abort_cyc - 2) / P;
                ph = (abort_cyc - 2) % P;
                if (ph < 1 + RD_LAT) begin
                    words = k; st = 3;
                end else begin
                    words = k + 1; st = (k == len) ? 0 : 3;
                end
                done_cyc = abort_cyc + 1;
            end
        end
    endfunction

    task automatic run_cmd(input bit op, input int ma, input int ra, input int len,
                           input logic [15:0] key, input int abort_cyc, input int hold);
        int st, words, done_cyc, k, ph;
        logic [3:0] exp_s;
        model(op, ma, ra, len, key, abort_cyc, st, words, done_cyc);
        @(negedge clk);
        chk("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid    = 1'b1;
        bus.cmd_op       = op;
        bus.cmd_mem_addr = 8'(ma);
        bus.cmd_reg_addr = 8'(ra);
        bus.cmd_len      = 4'(len);
        bus.cmd_key      = key;
        for (int cyc = 1; cyc <= done_cyc; cyc++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            if (cyc < done_cyc) begin
                exp_s = 4'b0000;
                k  = (cyc - 2) / P;
                ph = (cyc - 2) % P;
                if (cyc >= 2 && ph == 0)          exp_s = op ? 4'b0010 : 4'b1000;
                if (cyc >= 2 && ph == 1 + RD_LAT) exp_s = op ? 4'b0100 : 4'b0001;
                chk("strobes", 32'(strobes()), 32'(exp_s));
                chk("busy", 32'(busy), 32'd1);
                if (exp_s == 4'b1000) chk("mem_raddr", 32'(mem_read_address_reg), 32'((ma + k) & 255));
                if (exp_s == 4'b0001) chk("reg_waddr", 32'(reg_address_mem), 32'((ra + k) & 255));
                if (exp_s == 4'b0010) chk("reg_raddr", 32'(reg_address_to_mem), 32'((ra + k) & 255));
                if (exp_s == 4'b0100) chk("mem_waddr", 32'(mem_write_address_reg), 32'((ma + k) & 255));
            end
            abort = (cyc == abort_cyc);
        end
        exp_xfer = (exp_xfer + words) & 32'hFFFF;
        if (st == 1 && exp_deny < 255) exp_deny++;
        chk("resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("resp_status", 32'(bus.resp_status), 32'(st));
        chk("resp_words", 32'(bus.resp_words), 32'(words));
        chk("xfer_count", 32'(xfer_count), 32'(exp_xfer));
        chk("deny_count", 32'(deny_count), 32'(exp_deny));
        chk("done_strobes", 32'(strobes()), 32'd0);
        chk("cmd_ready_done", 32'(bus.cmd_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            bus.cmd_valid = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            chk("hold_resp_valid", 32'(bus.resp_valid), 32'd1);
            chk("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            chk("hold_status", 32'(bus.resp_status), 32'(st));
        end
        bus.cmd_valid  = 1'b0;
        abort          = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk("resp_drop", 32'(bus.resp_valid), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int op, ma, ra, len, ac, dc, st, wd;
        logic [15:0] key;
        rst_n            = 1'b0;
        abort            = 1'b0;
        key_access_mem   = 16'h1234;
        key_access_reg   = 16'h5678;
        bus.cmd_valid    = 1'b0;
        bus.cmd_op       = 1'b0;
        bus.cmd_mem_addr = 8'd0;
        bus.cmd_reg_addr = 8'd0;
        bus.cmd_len      = 4'd0;
        bus.cmd_key      = 16'd0;
        bus.resp_ready   = 1'b0;
        #12;
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_strobes", 32'(strobes()), 32'd0);
        chk("rst_addrs", {mem_read_address_reg, mem_write_address_reg, reg_address_to_mem, reg_address_mem}, 32'd0);
        chk("rst_resp", {29'd0, bus.resp_valid, bus.resp_status}, 32'd0);
        chk("rst_counts", {8'd0, xfer_count, deny_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("cmd_ready_after_rst", 32'(bus.cmd_ready), 32'd1);

        run_cmd(1'b0, 8'h10, 8'h04, 0, 16'h1234, -1, 0);
        run_cmd(1'b1, 8'h80, 8'h20, 3, 16'h5678, -1, 0);
        run_cmd(1'b0, 8'h10, 8'h04, 0, 16'hBEEF, -1, 0);
        run_cmd(1'b0, 8'hFE, 8'h00, 3, 16'h1234, -1, 0);
        run_cmd(1'b0, 8'hFE, 8'h00, 3, 16'hBEEF, -1, 0);
        run_cmd(1'b1, 8'h00, 8'h10, 7, 16'h5678, 2 + 2 * P + 1, 0);
        run_cmd(1'b1, 8'h00, 8'h10, 7, 16'h5678, 2 + 7 * P + 1 + RD_LAT, 0);
        run_cmd(1'b0, 8'h30, 8'h40, 5, 16'h1234, 2 + 3 * P, 0);
        run_cmd(1'b0, 8'h30, 8'h40, 5, 16'h1234, 2 + 1 * P + 1 + RD_LAT, 0);
        run_cmd(1'b1, 8'hF0, 8'h01, 15, 16'h5678, -1, 0);
        run_cmd(1'b0, 8'h05, 8'h06, 1, 16'h1234, -1, 10);

        for (int n = 0; n < 60; n++) begin
            key_access_mem = 16'($urandom);
            key_access_reg = 16'($urandom);
            op  = int'($urandom_range(1, 0));
            ma  = int'($urandom_range(255, 0));
            ra  = int'($urandom_range(255, 0));
            if ($urandom_range(1, 0) == 1) begin
                ma = ma & 8'hEF;
                ra = ra & 8'hEF;
            end
            len = int'($urandom_range(15, 0));
            key = ($urandom_range(9, 0) < 8) ? (op != 0 ? key_access_reg : key_access_mem) : 16'($urandom);
            ac  = -1;
            if ($urandom_range(9, 0) < 4) begin
                model(op[0], ma, ra, len, key, -1, st, wd, dc);
                ac = int'($urandom_range(32'(dc + 1), 0));
            end
            run_cmd(op[0], ma, ra, len, key, ac, 0);
        end

        key_access_mem = 16'h1234;
        for (int n = 0; n < 300; n++) begin
            run_cmd(1'b0, 8'h10, 8'h04, 0, 16'hBEEF, -1, 0);
        end
        chk("deny_saturated", 32'(deny_count), 32'd255);

        // Reset during a burst abandons it without a response.
        key_access_reg = 16'h5678;
        @(negedge clk);
        bus.cmd_valid    = 1'b1;
        bus.cmd_op       = 1'b1;
        bus.cmd_mem_addr = 8'h80;
        bus.cmd_reg_addr = 8'h20;
        bus.cmd_len      = 4'd7;
        bus.cmd_key      = 16'h5678;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_read", 32'(reg_renable_mem), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_strobes", 32'(strobes()), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_xfer", 32'(xfer_count), 32'd0);
        chk("mid_rst_deny", 32'(deny_count), 32'd0);
        chk("mid_rst_resp", 32'(bus.resp_valid), 32'd0);
        exp_xfer = 0;
        exp_deny = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(bus.cmd_ready), 32'd1);
        chk("post_rst_resp", 32'(bus.resp_valid), 32'd0);
        run_cmd(1'b0, 8'h10, 8'h04, 2, 16'h1234, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sec_xfer_ctrl.md
Name: sec_xfer_ctrl

Overview:
- Transfer initiator that drives the memory-side and register-side transfer ports through the security path.
- Replaces the externally driven enables and addresses with a command/response sequencer.
- Accepts load commands (memory->registers) and store commands (registers->memory) of 1..16 words.
- Checks the access key, issues read-then-write enable pulses per word, and returns a status.
- It moves no data; data flows memory<->security<->registers under its enables.

Parameters:
- RD_LAT, 1, cycles from source read enable to data valid at the destination (1..4).
- CNT_W, 16, width of the completed-word counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  1  0=load (mem->reg), 1=store (reg->mem)
- cmd_mem_addr  in  8  first memory word address
- cmd_reg_addr  in  8  first register address
- cmd_len  in  4  word count minus 1
- cmd_key  in  16  requester key
- key_access_mem  in  16  key published by memory
- key_access_reg  in  16  key published by register file
- abort  in  1  request early termination
- mem_read_address_reg  out  8  memory read address (load)
- mem_renable_reg  out  1  memory read strobe
- mem_write_address_reg  out  8  memory write address (store)
- mem_wenable_reg  out  1  memory write strobe
- reg_address_to_mem  out  8  register read address (store)
- reg_renable_mem  out  1  register read strobe
- reg_address_mem  out  8  register write address (load)
- reg_wenable_mem  out  1  register write strobe
- resp_valid  out  1  response present, held until accepted
- resp_ready  in  1  response consumer ready
- resp_status  out  2  0=OK, 1=KEY_DENIED, 2=RANGE_ERR, 3=ABORTED
- resp_words  out  5  words actually written (0..16)
- busy  out  1  high when state is not IDLE
- xfer_count  out  CNT_W  total words written; wraps
- deny_count  out  8  key denials; saturates at 255

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All strobes 0, all addresses 0.
  - resp_valid=0, resp_status=0, resp_words=0.
  - xfer_count=0, deny_count=0.
  - cmd_ready rises in the first cycle after rst_n deasserts.
  - Reset mid-transfer abandons it; no partial response is produced.
- Strobes and addresses are Moore outputs of registered state. Each strobe is high for exactly one cycle per word.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch op, addresses, len and key; go to CHECK.
- CHECK (1 cycle):
  - A load requires cmd_key==key_access_mem; a store requires cmd_key==key_access_reg.
  - On mismatch: status 1 and deny_count+1 (saturating).
  - Otherwise, if either address+len>255 (9-bit compare, no wrap): status 2.
  - Key denial takes priority over range error.
  - On any failure go to DONE with words=0 and no strobes issued. Otherwise go to READ.
- READ (1 cycle):
  - Load: mem_renable_reg=1 at the current memory address.
  - Store: reg_renable_mem=1 at the current register address.
  - Then go to WAIT.
- WAIT (RD_LAT cycles): no strobes. Then go to WRITE.
- WRITE (1 cycle):
  - Load: reg_wenable_mem=1 at the current register address.
  - Store: mem_wenable_reg=1 at the current memory address.
  - Increment words and xfer_count.
  - If the word count is now len+1, go to DONE with status 0.
  - Otherwise increment both addresses and go to READ.
- abort:
  - Sampled in READ or WAIT: the current word is dropped (no write), go to DONE with status 3.
  - In WRITE: the write completes first, then DONE with status 3, unless it was the last word (status 0).
  - Ignored in IDLE, CHECK and DONE.
- DONE:
  - resp_valid=1; status and words are held stable.
  - On resp_ready, go to IDLE next cycle; resp_valid drops.
  - cmd_ready=0 throughout DONE, so no command overlaps a pending response.
- Latency, RD_LAT=1, single word (accept at cycle 0): CHECK at 1, READ at 2, WAIT at 3, WRITE at 4, resp_valid at 5. Each extra word adds 2+RD_LAT cycles.
- Simultaneous events:
  - cmd_valid during DONE is not accepted.
  - An xfer_count increment on the same cycle as its wrap yields 0.

Test Plan:
- Reset then load, mem 0x10->reg 0x04, len=0, matching key, RD_LAT=1 -> mem_renable_reg at cycle 2 (addr 0x10); reg_wenable_mem at cycle 4 (addr 0x04); resp_valid at cycle 5, status 0, words 1; xfer_count=1.
- Store, reg 0x20->mem 0x80, len=3 -> four read/write pairs at addresses 0x20..0x23 / 0x80..0x83, 3 cycles apart; status 0, words 4, xfer_count +4.
- Load with cmd_key=0xBEEF, key_access_mem=0x1234 -> no strobes ever; status 1, words 0, deny_count +1. Repeat 300 times -> deny_count=255.
- Load at mem_addr=0xFE, len=3 -> status 2, no strobes. Same command with a bad key -> status 1.
- Store, len=7, abort pulsed during the WAIT of word 3 -> exactly 2 writes; status 3, words 2. Abort during the WRITE of the final word -> status 0, words 8.
- resp_ready held low 10 cycles with cmd_valid high -> resp_valid stays high and cmd_ready stays 0. rst_n pulsed low mid-burst -> all strobes 0 immediately, busy=0, counters 0.
